// File: rtl/sg13g2_latch_regfile.sv
// sg13g2_latch_regfile: latch-array register file with flop-staged writes strobed into latches during CLK low
module sg13g2_dlhrq #(
    parameter int DRIVE_LEVEL = 1
) (
    input  logic D,
    input  logic RESET_B,
    input  logic GATE,
    output logic Q
);
    if (DRIVE_LEVEL < 1) begin : g_bad_drive
        $error("sg13g2_dlhrq: DRIVE_LEVEL must be >= 1");
    end
    // High-transparent latch; reset dominates the gate
    always_latch begin
        if (!RESET_B) Q <= 1'b0;
        else if (GATE) Q <= D;
    end
endmodule

module sg13g2_latch_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    parameter int DRIVE_LEVEL = 1,
    parameter bit BYPASS = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_all,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [DEPTH-1:0] valid,
    output logic             wr_err
);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    if (DEPTH < 2 || WIDTH < 1) begin : g_bad_cfg
        $error("sg13g2_latch_regfile: need DEPTH >= 2 and WIDTH >= 1");
    end
    logic                        wr_pend_q, wr_pend_d;
    logic                        wr_err_q, wr_err_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [WIDTH-1:0]            data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            wr_dec, gate_sel, gate;
    logic [DEPTH-1:0][WIDTH-1:0] entry;
    logic                        wr_ok;
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);
    // Next state of the staging flops, error pulse and valid flags
    always_comb begin
        wr_pend_d = wr_ok;
        addr_d    = wr_addr;
        data_d    = wr_data;
        wr_err_d  = wr_en && !wr_ok;
        valid_d   = (clr_all ? '0 : valid_q) | wr_dec;
    end
    // Write staging and valid flags; everything clears asynchronously, dropping any pending write
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            wr_pend_q <= 1'b0;
            wr_err_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            wr_err_q  <= wr_err_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end
    // Strobe decode comes only from flops, so its settling while CLK is high is masked by the AND with ~CLK
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [WIDTH-1:0] row;
        assign wr_dec[g]   = wr_ok && (wr_addr == AW'(g));
        assign gate_sel[g] = wr_pend_q && (addr_q == AW'(g));
        assign gate[g]     = gate_sel[g] & ~CLK;
        assign entry[g]    = row;
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            sg13g2_dlhrq #(
                .DRIVE_LEVEL(DRIVE_LEVEL)
            ) u_lat (
                .D      (data_q[b]),
                .RESET_B(RESET_B),
                .GATE   (gate[g]),
                .Q      (row[b])
            );
        end
    end
    // Read mux; out-of-range addresses read zero, a staged write to the same entry is forwarded when enabled
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data  = (BYPASS && wr_pend_q && addr_q == rd_addr) ? data_q : entry[i];
                rd_valid = valid_q[i];
            end
        end
    end
    assign valid  = valid_q;
    assign wr_err = wr_err_q;
endmodule

// File: tb/tb_sg13g2_latch_regfile.sv
// tb_sg13g2_latch_regfile: scoreboard bench over bypass, no-bypass and DEPTH=3 instances
module tb_sg13g2_latch_regfile;
    logic       CLK = 1'b0, RESET_B = 1'b0, wr_en = 1'b0, clr_all = 1'b0;
    logic [1:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data, rd_data_nb, rd_data_3;
    logic       rd_valid, rd_valid_nb, rd_valid_3;
    logic       wr_err, wr_err_nb, wr_err_3;
    logic [3:0] valid, valid_nb;
    logic [2:0] valid_3;
    int         passed = 0, total = 0;
    logic [7:0] m_mem [4];
    logic [3:0] m_valid;
    logic [7:0] exp_q [$];
    logic [7:0] exp, exp_old;

    always #5 CLK = ~CLK;

    sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(4), .DRIVE_LEVEL(1), .BYPASS(1'b1)) dut (
        .CLK(CLK), .RESET_B(RESET_B), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_all(clr_all), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .valid(valid), .wr_err(wr_err));
    sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(4), .DRIVE_LEVEL(1), .BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RESET_B(RESET_B), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_all(clr_all), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_valid(rd_valid_nb),
        .valid(valid_nb), .wr_err(wr_err_nb));
    sg13g2_latch_regfile #(.WIDTH(8), .DEPTH(3), .DRIVE_LEVEL(1), .BYPASS(1'b1)) dut3 (
        .CLK(CLK), .RESET_B(RESET_B), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_all(clr_all), .rd_addr(rd_addr), .rd_data(rd_data_3), .rd_valid(rd_valid_3),
        .valid(valid_3), .wr_err(wr_err_3));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic low();
        @(negedge CLK);
        #1;
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
        m_mem[a] = d;
        m_valid[a] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        m_valid = '0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            wr_en = 1'($urandom);
            wr_addr = 2'($urandom);
            wr_data = 8'($urandom);
            clr_all = 1'($urandom);
            rd_addr = 2'(c);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            step();
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp || rd_data_nb !== exp || rd_data_3 !== exp)
                $display("FAIL reset_rd_high[%0d]: got %h/%h/%h exp %h", c, rd_data, rd_data_nb, rd_data_3, exp);
            else passed++;
            total++;
            if ({valid, valid_nb, valid_3, wr_err, wr_err_nb, wr_err_3, rd_valid, rd_valid_nb, rd_valid_3} !== 16'h0)
                $display("FAIL reset_flags[%0d]: valid %b/%b/%b wr_err %b%b%b rd_valid %b%b%b exp all 0",
                         c, valid, valid_nb, valid_3, wr_err, wr_err_nb, wr_err_3, rd_valid, rd_valid_nb, rd_valid_3);
            else passed++;
            low();
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp || rd_data_nb !== exp || rd_data_3 !== exp)
                $display("FAIL reset_rd_low[%0d]: got %h/%h/%h exp %h", c, rd_data, rd_data_nb, rd_data_3, exp);
            else passed++;
        end
        step();
        wr_en = 1'b0;
        clr_all = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        RESET_B = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_write_read();
        write(2'd1, 8'hA5);
        write(2'd2, 8'h3C);
        step();
        for (int a = 1; a <= 2; a++) begin
            rd_addr = 2'(a);
            exp_q.push_back(m_mem[a]);
            step();
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp || rd_data_nb !== exp || rd_valid !== 1'b1)
                $display("FAIL write_read[%0d]: got %h/%h valid %b exp %h valid 1", a, rd_data, rd_data_nb, rd_valid, exp);
            else passed++;
        end
        total++;
        if (valid !== m_valid || valid_nb !== m_valid)
            $display("FAIL write_read_valid: got %b/%b exp %b", valid, valid_nb, m_valid);
        else passed++;
        total++;
        if (valid_3 !== m_valid[2:0])
            $display("FAIL write_read_valid3: got %b exp %b", valid_3, m_valid[2:0]);
        else passed++;
    endtask

    task automatic test_bypass();
        write(2'd3, 8'h77);
        step();
        step();
        exp_old = m_mem[3];
        rd_addr = 2'd3;
        wr_en = 1'b1;
        wr_addr = 2'd3;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        m_mem[3] = 8'h5A;
        exp_q.push_back(m_mem[3]);
        exp_q.push_back(exp_old);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) $display("FAIL bypass_high: got %h exp %h", rd_data, exp);
        else passed++;
        exp = exp_q.pop_front();
        total++;
        if (rd_data_nb !== exp) $display("FAIL nobypass_high_old: got %h exp %h", rd_data_nb, exp);
        else passed++;
        exp_q.push_back(m_mem[3]);
        low();
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp) $display("FAIL bypass_low: got %h exp %h", rd_data, exp);
        else passed++;
        exp_q.push_back(m_mem[3]);
        step();
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp || rd_data_nb !== exp)
            $display("FAIL bypass_next_edge: got %h/%h exp %h", rd_data, rd_data_nb, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        rd_addr = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            write(2'd0, 8'(k));
            exp_q.push_back(8'(k));
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp) $display("FAIL b2b_bypass[%0d]: got %h exp %h", k, rd_data, exp);
            else passed++;
        end
        step();
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            exp_q.push_back(m_mem[a]);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (rd_data !== exp || rd_data_nb !== exp)
                $display("FAIL b2b_entry[%0d]: got %h/%h exp %h", a, rd_data, rd_data_nb, exp);
            else passed++;
        end
    endtask

    task automatic test_depth3();
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        m_valid = '0;
        total++;
        if (valid !== m_valid || valid_3 !== m_valid[2:0])
            $display("FAIL clr_all: got %b/%b exp %b", valid, valid_3, m_valid);
        else passed++;
        write(2'd3, 8'hEE);
        total++;
        if (wr_err_3 !== 1'b1 || wr_err !== 1'b0)
            $display("FAIL d3_wr_err_pulse: got %b/%b exp 1/0", wr_err_3, wr_err);
        else passed++;
        rd_addr = 2'd3;
        exp_q.push_back(8'h00);
        exp_q.push_back(m_mem[3]);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (rd_data_3 !== exp || rd_valid_3 !== 1'b0)
            $display("FAIL d3_oob_read: got %h valid %b exp %h valid 0", rd_data_3, rd_valid_3, exp);
        else passed++;
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp || rd_valid !== 1'b1)
            $display("FAIL d4_addr3_read: got %h valid %b exp %h valid 1", rd_data, rd_valid, exp);
        else passed++;
        step();
        total++;
        if (wr_err_3 !== 1'b0) $display("FAIL d3_wr_err_clear: got %b exp 0", wr_err_3);
        else passed++;
        total++;
        if (valid_3 !== 3'b000 || valid !== m_valid)
            $display("FAIL d3_valid: got %b/%b exp 000/%b", valid_3, valid, m_valid);
        else passed++;
        for (int a = 0; a < 3; a++) begin
            rd_addr = 2'(a);
            exp_q.push_back(m_mem[a]);
            #1;
            exp = exp_q.pop_front();
            total++;
            if (rd_data_3 !== exp) $display("FAIL d3_entry[%0d]: got %h exp %h", a, rd_data_3, exp);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        rd_addr = 2'd2;
        write(2'd2, 8'hFF);
        exp_q.push_back(m_mem[2]);
        low();
        exp = exp_q.pop_front();
        total++;
        if (rd_data_nb !== exp) $display("FAIL low_phase_strobe: got %h exp %h", rd_data_nb, exp);
        else passed++;
        RESET_B = 1'b0;
        model_reset();
        exp_q.push_back(m_mem[2]);
        #1;
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp || rd_data_nb !== exp || rd_data_3 !== exp || valid !== m_valid)
            $display("FAIL async_reset: got %h/%h/%h valid %b exp %h valid %b",
                     rd_data, rd_data_nb, rd_data_3, valid, exp, m_valid);
        else passed++;
        step();
        RESET_B = 1'b1;
        step();
        exp_q.push_back(m_mem[2]);
        exp = exp_q.pop_front();
        total++;
        if (rd_data !== exp || rd_data_nb !== exp || rd_valid !== 1'b0 || valid[2] !== 1'b0)
            $display("FAIL after_reset_entry2: got %h/%h rd_valid %b valid2 %b exp %h 0 0",
                     rd_data, rd_data_nb, rd_valid, valid[2], exp);
        else passed++;
        write(2'd0, 8'h44);
        total++;
        if (valid !== m_valid) $display("FAIL valid_set: got %b exp %b", valid, m_valid);
        else passed++;
        clr_all = 1'b1;
        m_valid = '0;
        write(2'd1, 8'h11);
        clr_all = 1'b0;
        total++;
        if (valid !== m_valid || valid_3 !== m_valid[2:0])
            $display("FAIL clr_and_write: got %b/%b exp %b", valid, valid_3, m_valid);
        else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_back_to_back();
        test_depth3();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
